// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset sequencer: states, opcodes,
// funct codes and the datapath mux/ALU select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_XOR   = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory-access watchdog: counts stalled cycles in a memory state and flags
// expiry on the cycle the count reaches MEM_TIMEOUT-1 while still stalled.
module mc_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  assign expire = count && (cnt == TO_W'(MEM_TIMEOUT - 1));

  // expiry restarts the count so a retried fetch gets a full window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || expire) cnt <= '0;
    else if (count)          cnt <= cnt + TO_W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS-subset datapath.
// Optional MC_PERF_CNT_EN adds retired-instruction and stall-cycle counters.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       sign_zero,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
`endif
);

  state_t state, state_nxt;
  logic   mem_st, wd_count, wd_expire;
  logic   unused_zero;

  // zero qualifies pc_write_cond in the datapath, not here
  assign unused_zero = zero;

  assign mem_st   = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign wd_count = mem_st && !mem_ready;

  mc_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!wd_count),
    .count  (wd_count),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_op        = ALU_ADD;
    sign_zero     = 1'b0;
    pc_source     = PCS_ALU;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
        else if (wd_expire) mem_err = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_RTYPE:     state_nxt = S_EXEC_R;
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_XORI:      state_nxt = S_EXEC_I;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_nxt  = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
        else if (wd_expire) begin
          mem_err   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEM_WR: begin
        // an abandoned store must not land in memory
        mem_write = !wd_expire;
        iord      = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
        else if (wd_expire) begin
          mem_err   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        alu_src_b = (funct == FN_SLL || funct == FN_SRL) ? SRCB_IMM : SRCB_REGB;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_XOR;
        sign_zero = 1'b1;
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        sign_zero = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ALUOUT;
        state_nxt     = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_RESET;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic retire;
  assign retire = (state == S_MEM_WB) || (state == S_R_WB) || (state == S_I_WB) ||
                  (state == S_BRANCH) || (state == S_JUMP) ||
                  (state == S_MEM_WR && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire)   instr_retired <= instr_retired + 32'd1;
      if (wd_count) stall_cycles  <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
